rgb888_raw8: RTL and testbench

Re-mosaics a registered RGB888 video stream into a single-channel 8-bit Bayer RAW stream, keeping for each pixel only the colour component its Bayer site would capture. It sits in the image-processing library as the inverse of the RAW8→RGB888 demosaic stage. It is used to synthesise sensor-like RAW input from RGB test images and to loop back through the demosaic path for regression. It also counts pixels per line and lines per frame and flags geometry mismatches.

---
 rtl/rgb888_raw8_if.sv | 24 ++
 rtl/rgb888_raw8.sv | 101 ++++++++++
 tb/tb_rgb888_raw8.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/rgb888_raw8_if.sv
// Stream bundle for the RGB888 -> Bayer RAW8 re-mosaic stage.
// The master drives the per_* pixel stream and the slave returns the post_* stream.
interface rgb888_raw8_if;
  logic       per_frame_vsync;
  logic       per_frame_href;
  logic [7:0] per_img_red;
  logic [7:0] per_img_green;
  logic [7:0] per_img_blue;
  logic       post_frame_vsync;
  logic       post_frame_href;
  logic [7:0] post_img_RAW;
  logic       post_line_err;
  logic       post_frame_err;

  modport master (
    output per_frame_vsync, per_frame_href, per_img_red, per_img_green, per_img_blue,
    input  post_frame_vsync, post_frame_href, post_img_RAW, post_line_err, post_frame_err
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, per_img_red, per_img_green, per_img_blue,
    output post_frame_vsync, post_frame_href, post_img_RAW, post_line_err, post_frame_err
  );
endinterface

// File: rtl/rgb888_raw8.sv
// Re-mosaics RGB888 into a Bayer RAW8 stream with one cycle of latency and
// flags line-length / frame-height mismatches against the configured geometry.
module rgb888_raw8 #(
  parameter logic [10:0] IMG_HDISP     = 11'd640,
  parameter logic [10:0] IMG_VDISP     = 11'd480,
  parameter logic [1:0]  BAYER_PATTERN = 2'd0
) (
  input  logic          clk,
  input  logic          rst_n,
  rgb888_raw8_if.slave  bus
);

  logic        href_q, href_d;
  logic        vsync_q, vsync_d;
  logic [10:0] pix_cnt_q, pix_cnt_d;
  logic [10:0] line_cnt_q, line_cnt_d;
  logic [10:0] lines_seen_q, lines_seen_d;
  logic [10:0] lines_eff;
  logic        line_arm_q, line_arm_d;
  logic        frame_arm_q, frame_arm_d;
  logic [7:0]  raw_q, raw_d;
  logic        line_err_q, line_err_d;
  logic        frame_err_q, frame_err_d;
  logic        href_fall, vsync_fall;
  logic [1:0]  site;

  always_comb begin
    href_d      = bus.per_frame_href;
    vsync_d     = bus.per_frame_vsync;
    href_fall   = href_q & ~bus.per_frame_href;
    vsync_fall  = vsync_q & ~bus.per_frame_vsync;

    pix_cnt_d = '0;
    if (bus.per_frame_href)
      pix_cnt_d = (pix_cnt_q == 11'h7FF) ? pix_cnt_q : pix_cnt_q + 11'd1;

    line_cnt_d = '0;
    if (bus.per_frame_vsync) begin
      line_cnt_d = line_cnt_q;
      if (href_fall)
        line_cnt_d = (line_cnt_q == IMG_VDISP - 11'd1) ? '0 : line_cnt_q + 11'd1;
    end

    // A line ending together with the frame is counted before the height check.
    lines_eff = lines_seen_q;
    if (href_fall && vsync_q && lines_seen_q != 11'h7FF)
      lines_eff = lines_seen_q + 11'd1;
    lines_seen_d = vsync_fall ? '0 : lines_eff;

    // Arm flags stay low until the input was seen idle, so a line or frame
    // already in flight when reset releases is never judged.
    line_arm_d  = line_arm_q  | ~bus.per_frame_href;
    frame_arm_d = frame_arm_q | ~bus.per_frame_vsync;

    line_err_d  = href_fall && line_arm_q && (pix_cnt_q != IMG_HDISP);
    frame_err_d = vsync_fall && frame_arm_q && (lines_eff != IMG_VDISP);

    site  = {line_cnt_q[0], pix_cnt_q[0]} ^ BAYER_PATTERN;
    raw_d = '0;
    if (bus.per_frame_href) begin
      unique case (site)
        2'b01:   raw_d = bus.per_img_red;
        2'b10:   raw_d = bus.per_img_blue;
        default: raw_d = bus.per_img_green;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      href_q       <= 1'b0;
      vsync_q      <= 1'b0;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      lines_seen_q <= '0;
      line_arm_q   <= 1'b0;
      frame_arm_q  <= 1'b0;
      raw_q        <= '0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      href_q       <= href_d;
      vsync_q      <= vsync_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      lines_seen_q <= lines_seen_d;
      line_arm_q   <= line_arm_d;
      frame_arm_q  <= frame_arm_d;
      raw_q        <= raw_d;
      line_err_q   <= line_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.post_frame_vsync = vsync_q;
  assign bus.post_frame_href  = href_q;
  assign bus.post_img_RAW     = raw_q;
  assign bus.post_line_err    = line_err_q;
  assign bus.post_frame_err   = frame_err_q;

endmodule

// File: tb/tb_rgb888_raw8.sv
// Directed bench: a 4x2 geometry with all four Bayer patterns side by side.
module tb_rgb888_raw8;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       vs, hr;
  logic [7:0] r, g, b;
  logic [7:0] raw [4];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Component captured at [pattern][line parity][pixel parity]: 0=R 1=G 2=B
  int site [4][2][2] = '{
    '{'{1, 0}, '{2, 1}},
    '{'{0, 1}, '{1, 2}},
    '{'{2, 1}, '{1, 0}},
    '{'{1, 2}, '{0, 1}}
  };

  always #5 clk = ~clk;

  rgb888_raw8_if if0 ();
  rgb888_raw8_if if1 ();
  rgb888_raw8_if if2 ();
  rgb888_raw8_if if3 ();

  assign if0.per_frame_vsync = vs; assign if0.per_frame_href = hr;
  assign if0.per_img_red = r; assign if0.per_img_green = g; assign if0.per_img_blue = b;
  assign if1.per_frame_vsync = vs; assign if1.per_frame_href = hr;
  assign if1.per_img_red = r; assign if1.per_img_green = g; assign if1.per_img_blue = b;
  assign if2.per_frame_vsync = vs; assign if2.per_frame_href = hr;
  assign if2.per_img_red = r; assign if2.per_img_green = g; assign if2.per_img_blue = b;
  assign if3.per_frame_vsync = vs; assign if3.per_frame_href = hr;
  assign if3.per_img_red = r; assign if3.per_img_green = g; assign if3.per_img_blue = b;

  assign raw[0] = if0.post_img_RAW;
  assign raw[1] = if1.post_img_RAW;
  assign raw[2] = if2.post_img_RAW;
  assign raw[3] = if3.post_img_RAW;

  rgb888_raw8 #(.IMG_HDISP(11'd4), .IMG_VDISP(11'd2), .BAYER_PATTERN(2'd0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  rgb888_raw8 #(.IMG_HDISP(11'd4), .IMG_VDISP(11'd2), .BAYER_PATTERN(2'd1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  rgb888_raw8 #(.IMG_HDISP(11'd4), .IMG_VDISP(11'd2), .BAYER_PATTERN(2'd2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  rgb888_raw8 #(.IMG_HDISP(11'd4), .IMG_VDISP(11'd2), .BAYER_PATTERN(2'd3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] pick(input int code, input logic [7:0] rr, gg, bb);
    return (code == 0) ? rr : (code == 1) ? gg : bb;
  endfunction

  task automatic cyc(input logic v, input logic h, input logic [7:0] rr, gg, bb);
    vs = v; hr = h; r = rr; g = gg; b = bb;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " vsync"}, 32'(if0.post_frame_vsync), 32'd0);
    check({tag, " href"},  32'(if0.post_frame_href),  32'd0);
    check({tag, " lerr"},  32'(if0.post_line_err),    32'd0);
    check({tag, " ferr"},  32'(if0.post_frame_err),   32'd0);
    for (int p = 0; p < 4; p++) check($sformatf("%s raw%0d", tag, p), 32'(raw[p]), 32'd0);
  endtask

  task automatic start_frame(input string tag);
    cyc(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    check({tag, " sof vsync"}, 32'(if0.post_frame_vsync), 32'd1);
    check({tag, " sof raw"},   32'(raw[0]), 32'd0);
  endtask

  // One active line followed by one blanking cycle (optionally the frame end).
  task automatic send_line(input string tag, input int npix, input int lpar,
                           input logic [7:0] rr, gg, bb,
                           input bit close_frame, input bit exp_lerr, input bit exp_ferr);
    for (int i = 0; i < npix; i++) begin
      cyc(1'b1, 1'b1, rr, gg, bb);
      check($sformatf("%s px%0d href", tag, i), 32'(if0.post_frame_href), 32'd1);
      if (i == 0) check({tag, " lerr idle"}, 32'(if0.post_line_err), 32'd0);
      for (int p = 0; p < 4; p++)
        check($sformatf("%s px%0d pat%0d", tag, i, p), 32'(raw[p]),
              32'(pick(site[p][lpar][i % 2], rr, gg, bb)));
    end
    cyc(close_frame ? 1'b0 : 1'b1, 1'b0, rr, gg, bb);
    check({tag, " blank raw"}, 32'(raw[0]), 32'd0);
    check({tag, " lerr"}, 32'(if0.post_line_err), 32'(exp_lerr));
    if (close_frame) check({tag, " ferr"}, 32'(if0.post_frame_err), 32'(exp_ferr));
  endtask

  task automatic end_frame(input string tag, input bit exp_ferr);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    check({tag, " eof vsync"}, 32'(if0.post_frame_vsync), 32'd0);
    check({tag, " eof lerr"},  32'(if0.post_line_err), 32'd0);
    check({tag, " eof ferr"},  32'(if0.post_frame_err), 32'(exp_ferr));
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    check({tag, " ferr drop"}, 32'(if0.post_frame_err), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    vs = 1'b0; hr = 1'b0; r = '0; g = '0; b = '0;
    cyc(1'b1, 1'b1, 8'h11, 8'h22, 8'h33);
    cyc(1'b0, 1'b1, 8'h44, 8'h55, 8'h66);
    cyc(1'b1, 1'b0, 8'h77, 8'h88, 8'h99);
    check_all_zero("rst");
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    check_all_zero("idle");

    // Constant colour frame across all four patterns
    start_frame("A");
    send_line("A l0", 4, 0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0);
    send_line("A l1", 4, 1, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0);
    end_frame("A", 1'b0);

    // Short first line, correct line count
    start_frame("B");
    send_line("B l0", 3, 0, 8'hA5, 8'h5A, 8'hC3, 1'b0, 1'b1, 1'b0);
    send_line("B l1", 4, 1, 8'hA5, 8'h5A, 8'hC3, 1'b0, 1'b0, 1'b0);
    end_frame("B", 1'b0);

    // Single-line frame
    start_frame("C");
    send_line("C l0", 4, 0, 8'h01, 8'h80, 8'hFF, 1'b0, 1'b0, 1'b0);
    end_frame("C", 1'b1);

    // Three lines: line counter wraps so line 2 has line-0 parity
    start_frame("D");
    send_line("D l0", 4, 0, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 1'b0);
    send_line("D l1", 4, 1, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 1'b0);
    send_line("D l2", 4, 0, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 1'b0);
    end_frame("D", 1'b1);

    // Zero-line frame
    start_frame("E");
    cyc(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    end_frame("E", 1'b1);

    // Last href fall coincides with vsync fall
    start_frame("F");
    send_line("F l0", 4, 0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0);
    send_line("F l1", 4, 1, 8'h10, 8'h20, 8'h30, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    check("F ferr after", 32'(if0.post_frame_err), 32'd0);

    // Reset in the middle of line 1
    start_frame("G");
    send_line("G l0", 4, 0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'h10, 8'h20, 8'h30);
    check("G l1 px0", 32'(raw[0]), 32'h30);
    cyc(1'b1, 1'b1, 8'h10, 8'h20, 8'h30);
    check("G l1 px1", 32'(raw[0]), 32'h20);
    rst_n = 1'b0;
    #1;
    check_all_zero("G async rst");
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    check_all_zero("G released");
    start_frame("H");
    send_line("H l0", 4, 0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0);
    send_line("H l1", 4, 1, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0);
    end_frame("H", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
